// File: rtl/i2c_reg_seq_config.sv
// Walks a register table held in an external registered ROM and issues one
// {SLAVE_ADDR, entry} transfer per entry, with delay entries, NACK retry and abort.
module i2c_reg_seq_config #(
  parameter int         CLK_FREQ   = 50000000,
  parameter int         I2C_FREQ   = 200000,
  parameter int         NUM_BYTE   = 3,
  parameter logic [7:0] SLAVE_ADDR = 8'h78,
  parameter int         TBL_SIZE   = 131,
  parameter int         ADDR_W     = 8,
  parameter int         MAX_RETRY  = 3,
  parameter int         AUTO_START = 1
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iSTART,
  output logic [ADDR_W-1:0]         oTBL_ADDR,
  input  logic [NUM_BYTE*8-1:0]     iTBL_DATA,
  output logic [(NUM_BYTE+1)*8-1:0] oXFER_DATA,
  output logic                      oXFER_GO,
  input  logic                      iXFER_END,
  input  logic                      iXFER_ACK,
  output logic                      oTICK,
  output logic                      oBUSY,
  output logic                      oREADY,
  output logic                      oERROR,
  output logic [ADDR_W-1:0]         oERR_INDEX
);

  localparam int DIV  = CLK_FREQ / (2 * I2C_FREQ);
  localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int UNIT = CLK_FREQ / 1000;
  localparam int DLW  = $clog2(255 * UNIT + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TBL_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT_END,
    S_WAIT_REL, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_index;
  logic [RW-1:0]           r_retry;
  logic [DLW-1:0]          r_dly;
  logic [NUM_BYTE*8-1:0]   r_entry;
  logic                    r_resend;
  logic                    r_auto_done;
  logic [TW-1:0]           r_tick_cnt;

  logic                    w_all_ones;
  logic                    w_upper_ones;
  logic [7:0]              w_last_byte;
  logic [DLW-1:0]          w_dly_load;
  logic                    w_start;

  assign oTBL_ADDR    = r_index;
  assign w_all_ones   = &iTBL_DATA;
  assign w_upper_ones = &iTBL_DATA[NUM_BYTE*8-1:8];
  assign w_last_byte  = iTBL_DATA[7:0];
  // The DELAY state lasts max(1, D*UNIT) cycles: it exits when the count reads zero.
  assign w_dly_load   = (w_last_byte == 8'h00) ? '0
                      : DLW'(w_last_byte) * DLW'(UNIT) - DLW'(1);
  assign w_start      = iSTART || ((AUTO_START != 0) && !r_auto_done);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset branch lists every register it owns.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_tick_cnt <= '0;
      oTICK      <= 1'b0;
    end else if (r_tick_cnt == TW'(DIV - 1)) begin
      r_tick_cnt <= '0;
      oTICK      <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
      oTICK      <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_entry     <= '0;
      r_resend    <= 1'b0;
      r_auto_done <= 1'b0;
      oXFER_DATA  <= '0;
      oXFER_GO    <= 1'b0;
      oBUSY       <= 1'b0;
      oREADY      <= 1'b0;
      oERROR      <= 1'b0;
      oERR_INDEX  <= '0;
    end else begin
      r_auto_done <= 1'b1;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (w_start) begin
            r_index <= '0;
            r_retry <= '0;
            oREADY  <= 1'b0;
            oERROR  <= 1'b0;
            oBUSY   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_all_ones) begin
            oREADY  <= 1'b1;
            oBUSY   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_upper_ones) begin
            r_dly   <= w_dly_load;
            r_state <= S_DELAY;
          end else begin
            r_entry <= iTBL_DATA;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          oXFER_DATA <= {SLAVE_ADDR, r_entry};
          oXFER_GO   <= 1'b1;
          r_state    <= S_WAIT_END;
        end
        S_WAIT_END: begin
          if (iXFER_END) begin
            oXFER_GO <= 1'b0;
            if (!iXFER_ACK) begin
              r_resend <= 1'b0;
              r_state  <= S_WAIT_REL;
            end else if (r_retry < RW'(MAX_RETRY)) begin
              r_retry  <= r_retry + RW'(1);
              r_resend <= 1'b1;
              r_state  <= S_WAIT_REL;
            end else begin
              oERROR     <= 1'b1;
              oERR_INDEX <= r_index;
              oBUSY      <= 1'b0;
              r_state    <= S_FAIL;
            end
          end
        end
        // Hold off the next GO until the engine has released END.
        S_WAIT_REL: begin
          if (!iXFER_END) r_state <= r_resend ? S_SEND : S_NEXT;
        end
        S_DELAY: begin
          if (r_dly == '0) r_state <= S_NEXT;
          else             r_dly   <= r_dly - DLW'(1);
        end
        S_NEXT: begin
          r_retry <= '0;
          if (r_index == LAST_IDX) begin
            oREADY  <= 1'b1;
            oBUSY   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + ADDR_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq_config.sv
// Directed bench for i2c_reg_seq_config: ROM and transfer-engine models,
// scoreboard of expected transfer words, tick-period monitor.
module tb_i2c_reg_seq_config;

  localparam int CLK_FREQ = 1000000;
  localparam int I2C_FREQ = 100000;
  localparam int NUM_BYTE = 3;
  localparam int TBL_SIZE = 8;
  localparam int ADDR_W   = 8;
  localparam int DIV      = CLK_FREQ / (2 * I2C_FREQ);
  localparam int DW       = NUM_BYTE * 8;
  localparam int XW       = (NUM_BYTE + 1) * 8;
  localparam int AI       = $clog2(TBL_SIZE);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DW-1:0]     tbl_data;
  logic [XW-1:0]     xfer_data;
  logic              xfer_go, xfer_end, xfer_ack;
  logic              tick, busy, ready, error;
  logic [ADDR_W-1:0] err_index;

  i2c_reg_seq_config #(
    .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .NUM_BYTE(NUM_BYTE),
    .TBL_SIZE(TBL_SIZE), .ADDR_W(ADDR_W)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start),
    .oTBL_ADDR(tbl_addr), .iTBL_DATA(tbl_data),
    .oXFER_DATA(xfer_data), .oXFER_GO(xfer_go),
    .iXFER_END(xfer_end), .iXFER_ACK(xfer_ack),
    .oTICK(tick), .oBUSY(busy), .oREADY(ready), .oERROR(error),
    .oERR_INDEX(err_index)
  );

  if (2**ADDR_W < TBL_SIZE) begin : g_addr_w_too_small
    initial $fatal(1, "FAIL addr_w_fits: 2**ADDR_W=%0d < TBL_SIZE=%0d", 2**ADDR_W, TBL_SIZE);
  end

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_tests++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Registered ROM: data follows the address by one clock.
  logic [DW-1:0] rom [0:TBL_SIZE-1];
  always @(posedge clk) tbl_data <= rom[tbl_addr[AI-1:0]];

  // Transfer engine model + scoreboard.
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] nack_data = '0;
  int            nack_left = 0;
  int            go_cnt    = 0;
  int            gap_last  = 0;
  int            t_fall    = 0;
  int            eng_st    = 0;
  int            eng_lat   = 0;
  logic          go_prev   = 1'b0;

  initial begin
    xfer_end = 1'b0;
    xfer_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (go_prev && !xfer_go) t_fall = cyc;
      if (!go_prev && xfer_go) begin
        go_cnt++;
        gap_last = cyc - t_fall;
        check("exp_q_nonempty_at_go", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("xfer_data", 64'(xfer_data), 64'(exp_q.pop_front()));
      end
      go_prev = xfer_go;
      case (eng_st)
        0: if (xfer_go) begin eng_lat = 3; eng_st = 1; end
        1: begin
          if (!xfer_go) eng_st = 0;
          else if (eng_lat > 0) eng_lat--;
          else begin
            xfer_end = 1'b1;
            xfer_ack = (xfer_data == nack_data) && (nack_left > 0);
            if (xfer_ack) nack_left--;
            eng_st = 2;
          end
        end
        default: begin xfer_end = 1'b0; xfer_ack = 1'b0; eng_st = 0; end
      endcase
    end
  end

  // Tick period monitor.
  int tick_bad  = 0;
  int tick_cnt  = 0;
  int last_tick = -1;
  initial forever begin
    @(negedge clk);
    if (rst) last_tick = -1;
    else if (tick) begin
      if (last_tick >= 0 && (cyc - last_tick) != DIV) tick_bad++;
      tick_cnt++;
      last_tick = cyc;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!(ready || error) && n < budget) begin @(negedge clk); n++; end
    check(tag, 64'(ready || error), 64'd1);
  endtask

  task automatic wait_go(input int budget);
    int n = 0;
    while (!xfer_go && n < budget) begin @(negedge clk); n++; end
    check("wait_go", 64'(xfer_go), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_go"},     64'(xfer_go),   64'd0);
    check({tag, "_data"},   64'(xfer_data), 64'd0);
    check({tag, "_addr"},   64'(tbl_addr),  64'd0);
    check({tag, "_busy"},   64'(busy),      64'd0);
    check({tag, "_ready"},  64'(ready),     64'd0);
    check({tag, "_error"},  64'(error),     64'd0);
    check({tag, "_erridx"}, 64'(err_index), 64'd0);
    check({tag, "_tick"},   64'(tick),      64'd0);
  endtask

  task automatic load_std(input logic [DW-1:0] e0, e1, e2, e3);
    for (int i = 0; i < TBL_SIZE; i++) rom[i] = '1;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  int gap1;

  initial begin
    rst   = 1'b1;
    start = 1'b0;

    // Scenario 1: plain table, auto start out of reset.
    load_std(24'h300880, 24'h310303, 24'hFFFFFF, 24'hFFFFFF);
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    go_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    check("auto_start_busy", 64'(busy), 64'd1);
    check("auto_start_addr", 64'(tbl_addr), 64'd0);
    wait_done(2000, "s1_done");
    check("s1_go_cnt", 64'(go_cnt), 64'd2);
    check("s1_ready", 64'(ready), 64'd1);
    check("s1_busy", 64'(busy), 64'd0);
    check("s1_error", 64'(error), 64'd0);
    check("s1_q_empty", 64'(exp_q.size()), 64'd0);
    gap1 = gap_last;

    // Scenario 2: 5 ms delay entry between the two transfers.
    load_std(24'h300880, 24'hFFFF05, 24'h310303, 24'hFFFFFF);
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    go_cnt = 0;
    pulse_start();
    wait_done(20000, "s2_done");
    check("s2_go_cnt", 64'(go_cnt), 64'd2);
    check_range("s2_delay_cycles", gap_last - gap1, 4997, 5003);
    check("s2_ready", 64'(ready), 64'd1);

    // Scenario 3: entry 2 NACKed twice, then accepted.
    load_std(24'h300880, 24'h310303, 24'h320101, 24'hFFFFFF);
    nack_data = 32'h78320101;
    nack_left = 2;
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    repeat (3) exp_q.push_back(32'h78320101);
    go_cnt = 0;
    pulse_start();
    wait_done(3000, "s3_done");
    check("s3_go_cnt", 64'(go_cnt), 64'd5);
    check("s3_ready", 64'(ready), 64'd1);
    check("s3_error", 64'(error), 64'd0);

    // Scenario 4: entry 2 always NACKed -> abort, then a clean rerun.
    nack_left = 1000;
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    repeat (4) exp_q.push_back(32'h78320101);
    go_cnt = 0;
    pulse_start();
    wait_done(3000, "s4_done");
    check("s4_go_cnt", 64'(go_cnt), 64'd6);
    check("s4_error", 64'(error), 64'd1);
    check("s4_err_index", 64'(err_index), 64'd2);
    check("s4_ready", 64'(ready), 64'd0);
    check("s4_busy", 64'(busy), 64'd0);
    nack_left = 0;
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    exp_q.push_back(32'h78320101);
    go_cnt = 0;
    pulse_start();
    check("s4_rerun_error_clr", 64'(error), 64'd0);
    wait_go(200);
    pulse_start();  // must be ignored while busy
    wait_done(3000, "s4_rerun_done");
    check("s4_rerun_go_cnt", 64'(go_cnt), 64'd3);
    check("s4_rerun_ready", 64'(ready), 64'd1);
    check("s4_rerun_error", 64'(error), 64'd0);

    // Scenario 5: reset while GO is high.
    exp_q.push_back(32'h78300880);
    pulse_start();
    wait_go(200);
    #1 rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h78300880);
    exp_q.push_back(32'h78310303);
    exp_q.push_back(32'h78320101);
    go_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    check("s5_refetch_busy", 64'(busy), 64'd1);
    check("s5_refetch_addr", 64'(tbl_addr), 64'd0);
    wait_done(3000, "s5_done");
    check("s5_go_cnt", 64'(go_cnt), 64'd3);
    check("s5_ready", 64'(ready), 64'd1);

    // Scenario 6: no end marker, bounded by TBL_SIZE.
    for (int i = 0; i < TBL_SIZE; i++) begin
      rom[i] = {8'h50 + 8'(i), 8'h10, 8'(i)};
      exp_q.push_back({8'h78, 8'h50 + 8'(i), 8'h10, 8'(i)});
    end
    go_cnt = 0;
    pulse_start();
    wait_done(5000, "s6_done");
    check("s6_go_cnt", 64'(go_cnt), 64'(TBL_SIZE));
    check("s6_ready", 64'(ready), 64'd1);
    check("s6_q_empty", 64'(exp_q.size()), 64'd0);
    check("tick_period_errors", 64'(tick_bad), 64'd0);
    check("tick_seen", 64'(tick_cnt > 100), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq_config.md
I2C_REG_SEQ_CONFIG -- requirements
Module: i2c_reg_seq_config

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: iCLK frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 200000: transfer-engine tick rate in Hz.
REQ-003 Parameter NUM_BYTE, default 3: bytes per table entry (register address plus data).
REQ-004 Parameter SLAVE_ADDR, default 8'h78: device write address prepended to every transfer.
REQ-005 Parameter TBL_SIZE, default 131: maximum number of table entries.
REQ-006 Parameter ADDR_W, default 8: table address width; the bench SHALL check that 2**ADDR_W >= TBL_SIZE.
REQ-007 Parameter MAX_RETRY, default 3: number of extra attempts after a NACK.
REQ-008 Parameter AUTO_START, default 1: start the sequence automatically when reset is released.
REQ-009 iCLK  in  1  sole clock; all logic is on the rising edge.
REQ-010 iRST  in  1  asynchronous, active-high reset.
REQ-011 iSTART  in  1  one-cycle pulse that re-runs the sequence from entry 0.
REQ-012 oTBL_ADDR  out  ADDR_W  table index presented to the external registered ROM.
REQ-013 iTBL_DATA  in  NUM_BYTE*8  ROM entry, valid 1 cycle after oTBL_ADDR changes.
REQ-014 oXFER_DATA  out  (NUM_BYTE+1)*8  {SLAVE_ADDR, entry} sent to the transfer engine.
REQ-015 oXFER_GO  out  1  transfer request.
REQ-016 iXFER_END  in  1  transfer complete.
REQ-017 iXFER_ACK  in  1  sampled with END; 1 = NACK (failure), 0 = acknowledged.
REQ-018 oTICK  out  1  one-cycle engine clock-enable pulse.
REQ-019 oBUSY / oREADY / oERROR  out  1 each  sequence running / completed OK / aborted.
REQ-020 oERR_INDEX  out  ADDR_W  index of the entry that failed.

Function
REQ-021 oTICK SHALL pulse once every DIV = CLK_FREQ/(2*I2C_FREQ) iCLK cycles, free-running, with the counter cleared by iRST.
REQ-022 The FSM SHALL have the states IDLE, FETCH, DECODE, SEND, WAIT_END, WAIT_REL, DELAY, NEXT, DONE and FAIL.
REQ-023 FETCH SHALL drive oTBL_ADDR = index and wait exactly 1 cycle; DECODE SHALL then classify the captured iTBL_DATA.
REQ-024 An entry that is all ones SHALL mark the end of the table; the FSM SHALL go to DONE.
REQ-025 Reaching index == TBL_SIZE SHALL also go to DONE.
REQ-026 An entry whose upper (NUM_BYTE-1) bytes are all ones and whose last byte D is not 8'hFF SHALL be a delay entry; DELAY SHALL wait D*(CLK_FREQ/1000) cycles, and D=0 is legal and SHALL take 1 cycle.
REQ-027 Any other entry SHALL go to SEND, which loads oXFER_DATA and asserts oXFER_GO.
REQ-028 oXFER_GO SHALL stay high until iXFER_END=1 is sampled in WAIT_END, then drop on the next cycle.
REQ-029 When END is sampled with ACK=0, the FSM SHALL go to WAIT_REL and then to NEXT.
REQ-030 When END is sampled with ACK=1 and retry_cnt < MAX_RETRY, the FSM SHALL increment retry_cnt, go to WAIT_REL, then return to SEND.
REQ-031 When END is sampled with ACK=1 and retry_cnt == MAX_RETRY, the FSM SHALL go to FAIL.
REQ-032 WAIT_REL SHALL hold until iXFER_END=0, so that a new GO never overlaps a stale END.
REQ-033 NEXT SHALL increment index, clear retry_cnt, and go to FETCH.
REQ-034 DONE SHALL assert oREADY=1 and oBUSY=0.
REQ-035 FAIL SHALL assert oERROR=1, set oERR_INDEX=index, and set oBUSY=0.
REQ-036 iSTART in IDLE, DONE or FAIL SHALL clear oREADY, oERROR and index, then go to FETCH.
REQ-037 iSTART in any other state SHALL be ignored.
REQ-038 oBUSY SHALL be 1 in every state except IDLE, DONE and FAIL.
REQ-039 The index counter SHALL be ADDR_W wide and SHALL never wrap; TBL_SIZE bounds it.
REQ-040 The delay counter SHALL be sized for 255*(CLK_FREQ/1000) cycles.

Reset
REQ-041 iRST=1 SHALL asynchronously force: state IDLE, index 0, retry_cnt 0, delay count 0, oXFER_GO 0, oXFER_DATA 0, oTBL_ADDR 0, oBUSY 0, oREADY 0, oERROR 0, oERR_INDEX 0, oTICK 0.
REQ-042 A reset asserted mid-transfer SHALL drop oXFER_GO immediately.
REQ-043 After reset is released, the block SHALL go IDLE→FETCH on the first cycle if AUTO_START=1; otherwise it SHALL stay IDLE until iSTART.

Verification
REQ-044 Bench parameters: CLK_FREQ=1000000, I2C_FREQ=100000, TBL_SIZE=8.
REQ-045 Scenario 1: table {0x300880, 0x310303, 0xFFFFFF} with every transfer ACKed → exactly 2 GO pulses, carrying 0x78300880 then 0x78310303; then oREADY=1, oBUSY=0.
REQ-046 Scenario 2: entry 1 = 0xFFFF05 → a gap of 5000±3 cycles between GO #1 and GO #2.
REQ-047 Scenario 3: the engine NACKs entry 2 twice, then ACKs → 3 GOs with identical data, then the sequence continues; oERROR=0.
REQ-048 Scenario 4: the engine NACKs entry 2 always → 4 GOs; then oERROR=1, oERR_INDEX=2, oREADY=0; a later iSTART reruns from entry 0.
REQ-049 Scenario 5: iRST pulse while oXFER_GO=1 → all outputs are 0 within the same cycle; after release, AUTO_START refetches entry 0.
REQ-050 Scenario 6: a table with no end marker → exactly TBL_SIZE=8 transfers; then oREADY=1, and oTICK period = 5 cycles throughout.
